// File: rtl/data_memory.sv
// data_memory: word-organised data memory with async clear and load-phase read suppression.
module data_memory #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              Startin,
  output logic [DATA_W-1:0] ReadData
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic inRange;
  logic unusedByteOffset;
  assign idx = Address[AW+1:2];
  // Any set bit above the word index means the address is past the end; no wrap-around.
  assign inRange = ~|Address[31:AW+2];
  assign unusedByteOffset = ^Address[1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (MemWrite && inRange)
      mem[idx] <= WriteData;
  assign ReadData = (MemRead && !Startin && inRange) ? mem[idx] : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed stimulus checked against a behavioural memory model every cycle.
module tb_data_memory;
  logic clk = 0;
  logic rst_n = 1;
  logic [31:0] Address = 0;
  logic [31:0] WriteData = 0;
  logic MemWrite = 0;
  logic MemRead = 0;
  logic Startin = 0;
  logic [31:0] ReadData;
  int checks = 0;
  int errors = 0;
  bit started = 0;
  logic [31:0] model [64];

  data_memory #(.DEPTH(64), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .Startin(Startin), .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      foreach (model[i]) model[i] = 32'h0;
    end else if (MemWrite && Address < 32'd256) begin
      model[Address / 4] = WriteData;
    end

  function automatic logic [31:0] expected();
    return (MemRead && !Startin && Address < 32'd256) ? model[Address / 4] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] exp);
    checks++;
    if (ReadData !== exp) begin
      errors++;
      $display("FAIL %s: addr=%h got %h expected %h", name, Address, ReadData, exp);
    end
  endtask

  always @(negedge clk)
    if (started) check("cycle", expected());

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    Address = a;
    #1;
    check(name, exp);
  endtask

  initial begin
    #1 rst_n = 0;
    started = 1;
    step();
    step();
    rst_n = 1;
    MemRead = 1;
    peek("reset_0", 32'h0, 32'h0);
    peek("reset_4", 32'h4, 32'h0);
    peek("reset_fc", 32'hFC, 32'h0);
    step();

    Startin = 1;
    WriteData = 32'hAAAAAAAA;
    MemWrite = 1;
    peek("load_gate_pre", 32'h4, 32'h0);
    step();
    MemWrite = 0;
    peek("load_gate_post", 32'h4, 32'h0);
    Startin = 0;
    peek("load_readback", 32'h4, 32'hAAAAAAAA);
    step();

    WriteData = 32'h12345678;
    MemWrite = 1;
    Address = 32'h8;
    step();
    MemWrite = 0;
    peek("alias_b", 32'hB, 32'h12345678);
    peek("alias_c", 32'hC, 32'h0);
    peek("alias_5", 32'h5, 32'hAAAAAAAA);

    MemRead = 0;
    peek("read_gate", 32'h8, 32'h0);
    MemRead = 1;
    MemWrite = 1;
    WriteData = 32'hDEADBEEF;
    peek("raw_before", 32'h8, 32'h12345678);
    step();
    MemWrite = 0;
    peek("raw_after", 32'h8, 32'hDEADBEEF);

    WriteData = 32'hFFFFFFFF;
    MemWrite = 1;
    Address = 32'h100;
    step();
    MemWrite = 0;
    peek("oor_read", 32'h100, 32'h0);
    peek("oor_nowrap", 32'h0, 32'h0);
    peek("oor_high", 32'hFFFFFFFC, 32'h0);
    peek("oor_keep4", 32'h4, 32'hAAAAAAAA);

    WriteData = 32'h13579BDF;
    MemWrite = 1;
    Address = 32'hFC;
    step();
    MemWrite = 0;
    peek("last_word", 32'hFF, 32'h13579BDF);
    step();

    Address = 32'h4;
    @(posedge clk);
    #1;
    check("pre_async", 32'hAAAAAAAA);
    rst_n = 0;
    #1;
    check("async_clear", 32'h0);
    MemWrite = 1;
    WriteData = 32'h55555555;
    step();
    MemWrite = 0;
    peek("write_in_reset", 32'h4, 32'h0);
    rst_n = 1;
    step();
    peek("post_reset_fc", 32'hFC, 32'h0);
    peek("post_reset_8", 32'h8, 32'h0);
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data memory for the single-cycle CPU datapath.
- Accepts byte addresses from the ALU result.
- Performs synchronous word writes on the rising clock edge.
- Returns read data combinationally within the same cycle.
- Startin marks the start-up/load phase, during which the memory may be written but reads are suppressed.

Parameters:
- DEPTH, 64, number of 32-bit words stored (power of two).
- DATA_W, 32, data word width.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset; clears every memory word to 0.
- Address  input  32  byte address; bits [1:0] ignored, bits [log2(DEPTH)+1:2] select the word.
- WriteData  input  32  data stored on a write.
- MemWrite  input  1  write enable, sampled at rising clk.
- MemRead  input  1  read enable, combinational.
- Startin  input  1  start-up/load phase flag, active high.
- ReadData  output  32  read data.

Behaviour:
- Reset:
  - rst_n low immediately, without waiting for clk, sets all DEPTH words to 32'h0000_0000.
  - ReadData therefore reads 0 for every address while and after reset.
  - Writes are ignored while rst_n is low.
  - Deassertion of rst_n is taken at the next rising clk.
- Word index: idx = Address[log2(DEPTH)+1:2]; Address[1:0] is don't-care, so 0x5, 0x6 and 0x7 all alias word 1.
- Range check:
  - Address >= 4*DEPTH is out of range.
  - Out-of-range writes are dropped; out-of-range reads return 0.
  - No wrap-around.
- Write:
  - At rising clk with rst_n=1, MemWrite=1 and Address in range: mem[idx] <= WriteData.
  - Full 32-bit word, no byte enables.
  - Writes are permitted whether Startin is 0 or 1.
- Read:
  - Combinational, zero latency.
  - ReadData = mem[idx] when MemRead=1, Startin=0 and Address is in range; otherwise 32'h0000_0000.
  - ReadData updates in the same delta as Address, MemRead, Startin or memory contents change.
- Simultaneous MemRead and MemWrite to the same word:
  - Before the edge, ReadData shows the old value.
  - After the edge, it shows the new value (read-after-write, no bypass).
- MemWrite and MemRead are independent; both may be high.
- MemWrite=0 leaves memory untouched regardless of the other inputs.
- Startin 1->0 transition: contents are preserved; reads become enabled immediately (combinational).
- Reset mid-operation: a write coincident with rst_n falling is lost; memory reads 0 afterwards.
- No X propagation: ReadData is never X after reset has been applied once.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1; MemRead=1, Startin=0, Address=0x0,0x4,0xFC -> ReadData=0x00000000 each.
- Load-phase write and read-back:
  - Startin=1, Address=0x4, WriteData=0xAAAAAAAA, MemWrite=1 for one rising edge; ReadData=0 while Startin=1.
  - Then Startin=0, MemWrite=0, MemRead=1, Address=0x4 -> ReadData=0xAAAAAAAA.
- Alignment alias: write 0x12345678 to Address 0x8; read Address 0xB -> 0x12345678; read 0xC -> 0x00000000.
- Read gating and read-after-write:
  - MemRead=0 at Address 0x8 -> 0x00000000.
  - MemRead=1 and MemWrite=1, Address 0x8, WriteData 0xDEADBEEF -> ReadData 0x12345678 before the edge, 0xDEADBEEF after it.
- Out of range (DEPTH=64): write 0xFFFFFFFF to 0x100 -> dropped; read 0x100 -> 0; read 0x0 unchanged.
- Async reset mid-run: after several writes, drive rst_n low between clock edges -> ReadData for 0x4 goes to 0 immediately, before the next rising clk.
